// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state and reset-cause types for the reset sequencer
package rst_seq_pkg;
   localparam int CAUSE_W = 2;
   typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_RUN} state_t;
   typedef enum logic [CAUSE_W-1:0] {
      CAUSE_POR  = 2'b00,
      CAUSE_SOFT = 2'b01,
      CAUSE_WDT  = 2'b10
   } cause_t;
endpackage

// File: rtl/rst_seq_wdt.sv
// rst_seq_wdt: watchdog that fires when enabled for WDT_CYCLES cycles without a kick
module rst_seq_wdt #(
   parameter int WDT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic kick,
   output logic expire
);
   localparam int W = $clog2(WDT_CYCLES);
   logic [W-1:0] cnt;
   assign expire = enable & ~kick & (cnt == W'(WDT_CYCLES - 1));
   always_ff @(posedge clk)
      cnt <= (reset | ~enable | kick | expire) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged multi-domain reset release; watchdog restart enabled by RESET_SEQ_WATCHDOG_EN
module reset_sequencer
   import rst_seq_pkg::*;
#(
   parameter int N_DOMAINS    = 3,
   parameter int PULSE_CYCLES = 4,
   parameter int STAGE_DELAY  = 2,
   parameter int WDT_CYCLES   = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 soft_req,
   input  logic                 wdt_kick,
   output logic [N_DOMAINS-1:0] rst_out,
   output logic                 busy,
   output logic [CAUSE_W-1:0]   cause
);
   localparam int CMAX = PULSE_CYCLES > STAGE_DELAY ? PULSE_CYCLES : STAGE_DELAY;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int IW   = $clog2(N_DOMAINS + 1);
   state_t        state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   cause_t        cause_q;
   logic          expire;
   logic          restart;
`ifdef RESET_SEQ_WATCHDOG_EN
   rst_seq_wdt #(.WDT_CYCLES(WDT_CYCLES)) u_wdt (
      .clk    (clk),
      .reset  (reset),
      .enable (state == ST_RUN),
      .kick   (wdt_kick),
      .expire (expire)
   );
`else
   logic unused_kick;
   assign unused_kick = wdt_kick & (WDT_CYCLES > 1);
   assign expire = 1'b0;
`endif
   assign restart = soft_req | expire;
   assign busy    = |rst_out;
   assign cause   = cause_q;
   // releases go in ascending order, so shifting zeros in from bit 0 clears rst_out[idx]
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_ASSERT;
         cnt     <= '0;
         idx     <= '0;
         rst_out <= '1;
         cause_q <= CAUSE_POR;
      end else if (restart) begin
         state   <= ST_ASSERT;
         cnt     <= '0;
         idx     <= '0;
         rst_out <= '1;
         cause_q <= soft_req ? CAUSE_SOFT : CAUSE_WDT;
      end else if (state == ST_ASSERT) begin
         if (cnt == CW'(PULSE_CYCLES - 1)) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            idx   <= '0;
         end else cnt <= cnt + 1'b1;
      end else if (state == ST_RELEASE) begin
         if (cnt == CW'(STAGE_DELAY - 1)) begin
            rst_out <= rst_out << 1;
            cnt     <= '0;
            idx     <= idx + 1'b1;
            if (idx == IW'(N_DOMAINS - 1)) state <= ST_RUN;
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed and random checks of reset_sequencer against an edge-count timing model
module tb_reset_sequencer;
   localparam int N = 3, P = 4, S = 2, W = 8;
`ifdef RESET_SEQ_WATCHDOG_EN
   localparam bit WDT_ON = 1'b1;
`else
   localparam bit WDT_ON = 1'b0;
`endif
   logic         clk = 1'b0;
   logic         reset = 1'b1, soft_req = 1'b0, wdt_kick = 1'b0;
   logic [N-1:0] rst_out;
   logic         busy, busy2;
   logic [1:0]   cause, cause2;
   logic [0:0]   rst_out2;
   int e = 0, s = 0, s2 = 0, last_kick = -1, exp_cause = 0, exp_cause2 = 0;
   int n_assert = 0, n_fail = 0;

   reset_sequencer #(.N_DOMAINS(N), .PULSE_CYCLES(P), .STAGE_DELAY(S), .WDT_CYCLES(W)) dut (
      .clk(clk), .reset(reset), .soft_req(soft_req), .wdt_kick(wdt_kick),
      .rst_out(rst_out), .busy(busy), .cause(cause));

   reset_sequencer #(.N_DOMAINS(1), .PULSE_CYCLES(1), .STAGE_DELAY(1), .WDT_CYCLES(16)) dut2 (
      .clk(clk), .reset(reset), .soft_req(soft_req), .wdt_kick(1'b1),
      .rst_out(rst_out2), .busy(busy2), .cause(cause2));

   always #5 clk = ~clk;

   // a sequence starting at edge s holds domain k until edge s+P+(k+1)*S
   task automatic model_edge(input logic r, input logic sr, input logic kk);
      int run_at, ref_e;
      run_at = s + P + N * S;
      ref_e  = last_kick > run_at ? last_kick : run_at;
      if (r) begin s = e; exp_cause = 0; end
      else if (sr) begin s = e; exp_cause = 1; end
      else if (WDT_ON && (e - 1) >= run_at && !kk && (e - ref_e) == W) begin s = e; exp_cause = 2; end
      if (kk) last_kick = e;
      if (r) begin s2 = e; exp_cause2 = 0; end
      else if (sr) begin s2 = e; exp_cause2 = 1; end
   endtask

   task automatic check();
      logic [N-1:0] exp_rst;
      logic [0:0]   exp_rst2;
      for (int k = 0; k < N; k++) exp_rst[k] = (e - s) < P + (k + 1) * S;
      exp_rst2[0] = (e - s2) < 2;
      n_assert++;
      assert (rst_out === exp_rst) else begin n_fail++; $error("FAIL rst_out edge=%0d got=%b exp=%b", e, rst_out, exp_rst); end
      n_assert++;
      assert (busy === |exp_rst) else begin n_fail++; $error("FAIL busy edge=%0d got=%b exp=%b", e, busy, |exp_rst); end
      n_assert++;
      assert (cause === 2'(exp_cause)) else begin n_fail++; $error("FAIL cause edge=%0d got=%b exp=%0d", e, cause, exp_cause); end
      n_assert++;
      assert (rst_out2 === exp_rst2 && busy2 === exp_rst2[0]) else begin n_fail++; $error("FAIL min_cfg edge=%0d got=%b/%b exp=%b", e, rst_out2, busy2, exp_rst2); end
      n_assert++;
      assert (cause2 === 2'(exp_cause2)) else begin n_fail++; $error("FAIL cause2 edge=%0d got=%b exp=%0d", e, cause2, exp_cause2); end
   endtask

   task automatic step(input logic r, input logic sr, input logic kk);
      reset = r; soft_req = sr; wdt_kick = kk;
      @(posedge clk);
      e++;
      model_edge(r, sr, kk);
      #1;
      check();
   endtask

   initial begin
      step(1, 0, 0); step(1, 0, 0);
      repeat (12) step(0, 0, 0);
      n_assert++;
      assert (rst_out === 3'b000 && cause === 2'b00) else begin n_fail++; $error("FAIL por_done got=%b/%b exp=000/00", rst_out, cause); end
      step(0, 1, 0); repeat (12) step(0, 0, 0);
      step(0, 1, 0); repeat (6) step(0, 0, 0);
      n_assert++;
      assert (rst_out === 3'b110) else begin n_fail++; $error("FAIL partial got=%b exp=110", rst_out); end
      step(0, 1, 0);
      n_assert++;
      assert (rst_out === 3'b111 && cause === 2'b01) else begin n_fail++; $error("FAIL soft_release got=%b/%b exp=111/01", rst_out, cause); end
      repeat (2) step(0, 0, 0);
      step(0, 1, 0); repeat (12) step(0, 0, 0);
      step(0, 1, 0); repeat (7) step(0, 0, 0);
      step(1, 1, 0);
      n_assert++;
      assert (rst_out === 3'b111 && cause === 2'b00) else begin n_fail++; $error("FAIL reset_prio got=%b/%b exp=111/00", rst_out, cause); end
      repeat (12) step(0, 0, 0);
`ifdef RESET_SEQ_WATCHDOG_EN
      repeat (20) step(0, 0, 0);
      n_assert++;
      assert (cause === 2'b10) else begin n_fail++; $error("FAIL wdt_cause got=%b exp=10", cause); end
      repeat (12) step(0, 0, 0);
      for (int i = 0; i < 100; i++) step(0, 0, (i % 5) == 4);
      n_assert++;
      assert (cause === 2'b10 && busy === 1'b0) else begin n_fail++; $error("FAIL wdt_kicked got=%b/%b exp=10/0", cause, busy); end
      step(0, 1, 0); repeat (10) step(0, 0, 0);
      repeat (7) step(0, 0, 0); step(0, 0, 1);
      repeat (7) step(0, 0, 0); step(0, 1, 0);
      repeat (12) step(0, 0, 0);
`endif
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter: N_DOMAINS, 3, number of reset domains driven (legal 1..16).
REQ-002 Parameter: PULSE_CYCLES, 4, cycles all domains stay asserted after a sequence starts (legal >=1).
REQ-003 Parameter: STAGE_DELAY, 2, cycles between successive domain releases (legal >=1).
REQ-004 Parameter: WDT_CYCLES, 1024, watchdog timeout in cycles (legal >=2).
REQ-005 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: soft_req  input  1  software reset request, sampled each cycle.
REQ-008 Port: wdt_kick  input  1  watchdog service strobe.
REQ-009 Port: rst_out  output  N_DOMAINS  per-domain active-high reset, registered.
REQ-010 Port: busy  output  1  high while any rst_out bit is high.
REQ-011 Port: cause  output  2  cause of the last sequence: 00 POR, 01 SOFT, 10 WDT.

Function
REQ-012 States SHALL be ASSERT, RELEASE, RUN; one cycle counter cnt and one domain index idx.
REQ-013 ASSERT: all rst_out high; cnt increments each cycle; at cnt==PULSE_CYCLES-1 go to RELEASE with cnt=0, idx=0.
REQ-014 RELEASE: at cnt==STAGE_DELAY-1 clear rst_out[idx], set cnt=0, idx+1; releasing idx==N_DOMAINS-1 goes to RUN.
REQ-015 Timing: counting edges from the first edge with reset low as 1, rst_out[k] SHALL be low after edge PULSE_CYCLES+(k+1)*STAGE_DELAY; domains release strictly in ascending index order; a released domain stays low until a new sequence.
REQ-016 busy SHALL equal the OR of rst_out (low exactly in RUN).
REQ-017 soft_req high in RUN: next cycle all rst_out high, state ASSERT, cnt=0, cause=01.
REQ-018 soft_req high in ASSERT: cnt restarts at 0 (extends the pulse), cause=01.
REQ-019 soft_req high in RELEASE: already-released domains reassert next cycle, state ASSERT, cnt=0, idx=0, cause=01.
REQ-020 cause SHALL change only when a sequence (re)starts and hold otherwise.
REQ-021 Counters SHALL be sized $clog2 of their maximum value plus one; no wrap-around in any legal configuration.

Reset
REQ-022 reset high (any state, mid-sequence included): next edge rst_out all ones, busy=1, cause=00, state ASSERT, cnt=0, idx=0, watchdog counter 0.
REQ-023 reset high takes priority over soft_req and watchdog expiry in the same cycle.

Configuration
REQ-024 Macro RESET_SEQ_WATCHDOG_EN: when defined, in RUN the watchdog counter increments each cycle, clears on wdt_kick, and at count WDT_CYCLES-1 without a kick starts a sequence with cause=10.
REQ-025 With the macro defined, a kick in the expiry cycle SHALL prevent expiry; simultaneous soft_req and expiry SHALL record cause=01; the counter SHALL be held at 0 outside RUN.
REQ-026 Without the macro: no watchdog logic, wdt_kick ignored, cause never 10.

Structure
REQ-027 Package rst_seq_pkg SHALL hold the state enum, the cause enum (CAUSE_POR, CAUSE_SOFT, CAUSE_WDT) and the 2-bit cause width constant.
REQ-028 The watchdog SHALL be sub-module rst_seq_wdt (clk, reset, enable, kick, expire), instantiated only under RESET_SEQ_WATCHDOG_EN.

Verification
REQ-029 Defaults, reset high 2 cycles then low -> rst_out 111 through edge 6, 110 after 6, 100 after 8, 000 after 10; busy low after 10; cause=00.
REQ-030 In RUN, soft_req for 1 cycle -> rst_out 111 next cycle, same release schedule relative to request, cause=01.
REQ-031 soft_req after rst_out[0] released (rst_out=110) -> 111 next cycle, full restart from ASSERT, cause=01.
REQ-032 Macro defined, WDT_CYCLES=8, no kick in RUN -> sequence starts after 8 RUN cycles, cause=10; kick every 5 cycles -> no sequence in 100 cycles.
REQ-033 reset asserted mid-RELEASE while soft_req high -> rst_out 111, cause=00; N_DOMAINS=1, PULSE_CYCLES=1, STAGE_DELAY=1 -> rst_out low after edge 2.
